uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Parametrised UART receiver with oversampling, majority-vote bit sampling, configurable frame format and an RX word FIFO.
//  Detects parity error, framing error, break and FIFO overrun. Sits between the board RX pin and the host-side register or
//  bus interface, which drains received words through a rd_en/dout_valid show-ahead interface.
// PARAMETERS
//  CLK_FREQ_HZ  100000000  system clock frequency in Hz
//  BAUDRATE     9600       line rate in bit/s
//  OVERSAMPLE   16         sample ticks per bit; even, >= 8
//  DATA_BITS    8          data bits per frame, 5..9, sent LSB first
//  STOP_BITS    1          stop bits checked, 1 or 2
//  FIFO_DEPTH   4          RX FIFO entries, power of 2, >= 2
// PORTS
//  clk        in   1          system clock
//  rst        in   1          asynchronous active-low reset
//  rx         in   1          serial input, asynchronous to clk, idle high
//  pen        in   1          parity enable
//  peven      in   1          1 = even parity, 0 = odd parity
//  rd_en      in   1          pop head word; ignored when dout_valid=0
//  ovr_clr    in   1          clears sticky overrun
//  dout       out  DATA_BITS  head word of the FIFO
//  dout_valid out  1          FIFO not empty
//  perr       out  1          parity error flag of head word
//  ferr       out  1          framing error flag of head word
//  brk        out  1          one-clk pulse when a break frame completes
//  overrun    out  1          sticky; set when a word arrives with FIFO full
//  busy       out  1          frame reception in progress
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, FSM IDLE, 2-FF rx synchroniser preset to 1. Reset mid-frame discards the partial frame.
//  - Tick: DIV = round(CLK_FREQ_HZ/(BAUDRATE*OVERSAMPLE)), minimum 1. One-clk tick every DIV clocks.
//    The tick counter and sample counter restart on start-edge detection.
//  - Vote: each bit is the majority of the synchronised rx at samples OVERSAMPLE/2-1, /2 and /2+1 within the bit.
//    The bit is decided on the tick of sample /2+1.
//  - FSM states:
//    IDLE: busy=0. Synchronised rx=0 -> START, busy=1. pen and peven are latched here; mid-frame changes are ignored.
//    START: if the start-bit vote is 1 (glitch), return to IDLE with no push. Otherwise go to DATA.
//    DATA: DATA_BITS bits, shifted LSB first. Then go to PARITY if pen is latched, else to STOP.
//    PARITY: perr_int = XOR(data, parity bit) ^ ~peven_l.
//      Even parity requires the XOR to be 0; odd parity requires it to be 1.
//    STOP: STOP_BITS votes. Any 0 sets ferr_int.
//      After the last stop vote: push {data, perr_int, ferr_int}, then go to IDLE if ferr_int=0, else to WAIT_HIGH.
//    WAIT_HIGH: busy=0. Stay until synchronised rx=1, then go to IDLE. A held-low line never retriggers a frame.
//  - Break: data all 0, parity bit 0 (if enabled) and first stop vote 0. The word is pushed with ferr=1 and brk pulses on the push cycle.
//  - perr is 0 for any word received with pen=0.
//  - Latency: the push occurs 1 clk after the final stop vote, and dout_valid rises the next clk.
//  - FIFO is show-ahead: dout, perr and ferr reflect the head entry combinationally from storage.
//    They are 0 after reset and do not care while dout_valid=0.
//    rd_en with dout_valid=1 pops at the clock edge, and the next entry appears the following cycle.
//  - Full: a push is dropped and overrun is set. Simultaneous push and pop while full is allowed: the push is kept and overrun stays 0.
//  - Empty: rd_en has no effect.
//  - Simultaneous push and pop on a 1-entry FIFO: the count stays 1 and the new word becomes the head.
//  - Pointers wrap modulo FIFO_DEPTH. The count register is $clog2(FIFO_DEPTH)+1 bits wide.
//  - overrun clears on ovr_clr. If ovr_clr and a new overrun occur in the same cycle, the set wins.
// TESTING
//  (bench: CLK_FREQ_HZ=1843200, BAUDRATE=115200, OVERSAMPLE=16 -> DIV=1; 16 clk per bit)
//  1 8N1, send 0xA5 -> dout=0xA5, dout_valid=1, perr=0, ferr=0; rd_en 1 clk -> dout_valid=0.
//  2 pen=1, peven=1: 0x37 with parity bit 1 -> perr=0. Same frame with parity bit 0 -> perr=1.
//    pen=1, peven=0 with 0x37 and parity bit 0 -> perr=0.
//  3 rx low for 4 clk then high -> no push, busy pulses then returns to 0, next frame 0x5A is received correctly.
//    Single-sample spike inside a data bit -> bit value unchanged.
//  4 rx low for 12 bit times -> one word 0x00 with ferr=1 and brk pulsed once. No further push until rx high.
//    Then frame 0x11 -> 0x11 received.
//  5 FIFO_DEPTH=4, send 0x01..0x05 with no reads -> 0x01..0x04 read back in order and overrun=1.
//    ovr_clr -> overrun=0. Pop concurrent with the 5th push -> no overrun.
//  6 DATA_BITS=7, STOP_BITS=2, odd parity, second stop bit 0 -> ferr=1, data correct.
//    Assert rst mid-DATA -> dout_valid=0, busy=0, next frame received cleanly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - oversampling UART receiver with 3-sample majority vote and show-ahead RX word FIFO
//  Ports: clk, rst (async active-low); rx serial input (idle high); pen/peven frame parity setup;
//  rd_en pops the head word; ovr_clr clears the sticky overrun; dout/perr/ferr show the head entry;
//  dout_valid = FIFO not empty; brk pulses on a break push; overrun sticky; busy = frame in progress.
module uart_rx_fifo #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUDRATE    = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 pen,
    input  logic                 peven,
    input  logic                 rd_en,
    input  logic                 ovr_clr,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    output logic                 perr,
    output logic                 ferr,
    output logic                 brk,
    output logic                 overrun,
    output logic                 busy
);
    localparam int BAUD_TICKS = BAUDRATE * OVERSAMPLE;
    localparam int DIV_RAW    = (CLK_FREQ_HZ + BAUD_TICKS / 2) / BAUD_TICKS;
    localparam int DIV        = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TCW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SCW        = $clog2(OVERSAMPLE);
    localparam int BCW        = $clog2(DATA_BITS + 1);
    localparam int PW         = $clog2(FIFO_DEPTH);
    localparam int CW         = PW + 1;
    localparam int EW         = DATA_BITS + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    state_t state, state_n;

    logic [1:0]           sync;
    logic                 rx_s;
    logic [TCW-1:0]       tick_cnt;
    logic                 tick;
    logic [SCW-1:0]       sample_cnt;
    logic                 v0, v1, vote, decide, start_det;
    logic                 pen_l, peven_l;
    logic [DATA_BITS-1:0] shreg;
    logic [BCW-1:0]       bit_cnt;
    logic                 stop_cnt, last_stop;
    logic                 perr_int, ferr_int, par_bit, first_stop, first_vote;
    logic                 push_req, brk_q;
    logic [EW-1:0]        push_word;

    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic                 full, pop, wr_ok;
    logic [EW-1:0]        head;

    // Two-flop synchroniser, preset to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync <= 2'b11;
        else      sync <= {sync[0], rx};
    end
    assign rx_s = sync[1];

    assign start_det = (state == S_IDLE) && !rx_s;

    // Tick and sample counters both restart on the start edge so the vote window is centred in each bit.
    assign tick = (tick_cnt == TCW'(DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt   <= '0;
            sample_cnt <= '0;
            v0         <= 1'b1;
            v1         <= 1'b1;
        end else if (start_det) begin
            tick_cnt   <= '0;
            sample_cnt <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TCW'(1);
            if (tick) begin
                sample_cnt <= (sample_cnt == SCW'(OVERSAMPLE - 1)) ? '0 : sample_cnt + SCW'(1);
                if (sample_cnt == SCW'(OVERSAMPLE / 2 - 1)) v0 <= rx_s;
                if (sample_cnt == SCW'(OVERSAMPLE / 2))     v1 <= rx_s;
            end
        end
    end

    // The third sample is the live synchronised value on the deciding tick.
    assign vote       = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
    assign decide     = tick && (sample_cnt == SCW'(OVERSAMPLE / 2 + 1));
    assign last_stop  = (stop_cnt == 1'(STOP_BITS - 1));
    assign first_vote = (stop_cnt == 1'b0) ? vote : first_stop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:      if (!rx_s) state_n = S_START;
            S_START:     if (decide) state_n = vote ? S_IDLE : S_DATA;
            S_DATA:      if (decide && bit_cnt == BCW'(DATA_BITS - 1))
                             state_n = pen_l ? S_PARITY : S_STOP;
            S_PARITY:    if (decide) state_n = S_STOP;
            S_STOP:      if (decide && last_stop)
                             state_n = (ferr_int || !vote) ? S_WAIT_HIGH : S_IDLE;
            S_WAIT_HIGH: if (rx_s) state_n = S_IDLE;
            default:     state_n = S_IDLE;
        endcase
    end

    assign busy = (state == S_START) || (state == S_DATA) ||
                  (state == S_PARITY) || (state == S_STOP);

    // Frame datapath; the completed word is registered and pushed one clock after the last stop vote.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pen_l      <= 1'b0;
            peven_l    <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            perr_int   <= 1'b0;
            ferr_int   <= 1'b0;
            par_bit    <= 1'b0;
            first_stop <= 1'b1;
            push_req   <= 1'b0;
            push_word  <= '0;
            brk_q      <= 1'b0;
        end else begin
            push_req <= 1'b0;
            brk_q    <= 1'b0;
            if (start_det) begin
                pen_l      <= pen;
                peven_l    <= peven;
                bit_cnt    <= '0;
                stop_cnt   <= 1'b0;
                perr_int   <= 1'b0;
                ferr_int   <= 1'b0;
                par_bit    <= 1'b0;
                first_stop <= 1'b1;
            end else if (decide) begin
                case (state)
                    S_DATA: begin
                        shreg   <= {vote, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + BCW'(1);
                    end
                    S_PARITY: begin
                        par_bit  <= vote;
                        perr_int <= (^shreg) ^ vote ^ ~peven_l;
                    end
                    S_STOP: begin
                        if (stop_cnt == 1'b0) first_stop <= vote;
                        if (!vote) ferr_int <= 1'b1;
                        stop_cnt <= stop_cnt + 1'b1;
                        if (last_stop) begin
                            push_req  <= 1'b1;
                            push_word <= {shreg, perr_int & pen_l, ferr_int | ~vote};
                            brk_q     <= (shreg == '0) && (!pen_l || !par_bit) && !first_vote;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign brk = brk_q;

    // When full, a push is still accepted if the head is popped in the same cycle: wr_ptr equals
    // rd_ptr then, so the new word lands in the slot being vacated.
    assign full  = (count == CW'(FIFO_DEPTH));
    assign pop   = rd_en && dout_valid;
    assign wr_ok = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            if (wr_ok && !pop)      count <= count + CW'(1);
            else if (!wr_ok && pop) count <= count - CW'(1);
            if (push_req && full && !pop) overrun <= 1'b1;
            else if (ovr_clr)             overrun <= 1'b0;
        end
    end

    assign dout_valid = (count != '0);
    assign head       = mem[rd_ptr];
    assign dout       = dout_valid ? head[EW-1:2] : '0;
    assign perr       = dout_valid & head[1];
    assign ferr       = dout_valid & head[0];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo (8N1 and 7-bit/2-stop instances)
module tb_uart_rx_fifo;
    localparam int CLK_HZ = 1843200;
    localparam int BAUD   = 115200;
    localparam int OS     = 16;
    localparam int BIT    = 16;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } word_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rx_a, pen_a, peven_a, rd_a, ovr_clr_a;
    logic [7:0] dout_a;
    logic       dv_a, perr_a, ferr_a, brk_a, ovr_a, busy_a;
    logic       rst_b, rx_b, pen_b, peven_b, rd_b, ovr_clr_b;
    logic [6:0] dout_b;
    logic       dv_b, perr_b, ferr_b, brk_b, ovr_b, busy_b;

    uart_rx_fifo #(.CLK_FREQ_HZ(CLK_HZ), .BAUDRATE(BAUD), .OVERSAMPLE(OS),
                   .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_a (
        .clk(clk), .rst(rst_a), .rx(rx_a), .pen(pen_a), .peven(peven_a), .rd_en(rd_a),
        .ovr_clr(ovr_clr_a), .dout(dout_a), .dout_valid(dv_a), .perr(perr_a), .ferr(ferr_a),
        .brk(brk_a), .overrun(ovr_a), .busy(busy_a));

    uart_rx_fifo #(.CLK_FREQ_HZ(CLK_HZ), .BAUDRATE(BAUD), .OVERSAMPLE(OS),
                   .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_b (
        .clk(clk), .rst(rst_b), .rx(rx_b), .pen(pen_b), .peven(peven_b), .rd_en(rd_b),
        .ovr_clr(ovr_clr_b), .dout(dout_b), .dout_valid(dv_b), .perr(perr_b), .ferr(ferr_b),
        .brk(brk_b), .overrun(ovr_b), .busy(busy_b));

    int    n_tests = 0;
    int    n_fail  = 0;
    word_t q_a[$];
    word_t q_b[$];
    word_t wa, wb;
    int    brk_cnt_a = 0, brk_cnt_b = 0, brk_exp_a = 0, brk_exp_b = 0;
    bit    auto_a = 0, auto_b = 0, conc_arm_a = 0, ovr_exp_a = 0;
    bit    prev_busy_a = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the word a frame should produce, from the frame contents alone.
    function automatic word_t ref_word(input logic [8:0] d, input int nb, input bit pe_en,
                                       input bit pev, input bit pbit, input bit st0,
                                       input bit st1, input int ns);
        word_t w;
        int    ones;
        ones = 0;
        for (int i = 0; i < nb; i++) ones += int'(d[i]);
        w.d  = d & 9'((1 << nb) - 1);
        w.pe = pe_en && (((ones + int'(pbit)) % 2) != (pev ? 0 : 1));
        w.fe = !st0 || (ns == 2 && !st1);
        return w;
    endfunction

    task automatic model_push(input int inst, input word_t w);
        if (inst == 0) begin
            if (!auto_a && q_a.size() >= DEPTH) ovr_exp_a = 1;
            else q_a.push_back(w);
        end else begin
            q_b.push_back(w);
        end
    endtask

    task automatic drive(input int inst, input bit v, input int clks, input int spike);
        for (int i = 0; i < clks; i++) begin
            @(negedge clk);
            if (inst == 0) rx_a = (i == spike) ? ~v : v;
            else           rx_b = (i == spike) ? ~v : v;
        end
    endtask

    task automatic send(input int inst, input logic [8:0] d, input bit pe_en, input bit pev,
                        input bit pbit, input bit st0, input bit st1,
                        input int spike_bit, input int spike_off);
        int nb;
        int ns;
        nb = (inst == 0) ? 8 : 7;
        ns = (inst == 0) ? 1 : 2;
        if (inst == 0) begin pen_a = pe_en; peven_a = pev; end
        else           begin pen_b = pe_en; peven_b = pev; end
        drive(inst, 1'b0, BIT, -1);
        for (int i = 0; i < nb; i++) drive(inst, d[i], BIT, (i == spike_bit) ? spike_off : -1);
        if (pe_en) drive(inst, pbit, BIT, -1);
        drive(inst, st0, BIT, -1);
        if (ns == 2) drive(inst, st1, BIT, -1);
        model_push(inst, ref_word(d, nb, pe_en, pev, pbit, st0, st1, ns));
        if (!st0 && ((d & 9'((1 << nb) - 1)) == 9'd0) && (!pe_en || !pbit)) begin
            if (inst == 0) brk_exp_a++;
            else           brk_exp_b++;
        end
        drive(inst, 1'b1, 2 * BIT, -1);
    endtask

    task automatic drain(input int inst, input string tag);
        int t;
        t = 0;
        while (((inst == 0) ? q_a.size() : q_b.size()) != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_drained"}, (inst == 0) ? q_a.size() : q_b.size(), 0);
        repeat (3) @(negedge clk);
        chk({tag, "_empty_after_pop"}, (inst == 0) ? dv_a : dv_b, 0);
    endtask

    // Monitor A: pops and compares when words appear; can also pop exactly on the cycle
    // after busy falls so the pop coincides with the push of the frame just completed.
    initial begin
        rd_a = 1'b0;
        forever begin
            @(negedge clk);
            if (brk_a) brk_cnt_a++;
            if (rd_a) begin
                rd_a = 1'b0;
            end else if (conc_arm_a && prev_busy_a && !busy_a) begin
                conc_arm_a = 0;
                wa = q_a.pop_front();
                chk("a_conc_head", dout_a, wa.d);
                rd_a = 1'b1;
            end else if (auto_a && dv_a && q_a.size() != 0) begin
                wa = q_a.pop_front();
                chk("a_dout", dout_a, wa.d);
                chk("a_perr", perr_a, wa.pe);
                chk("a_ferr", ferr_a, wa.fe);
                rd_a = 1'b1;
            end
            prev_busy_a = busy_a;
        end
    end

    initial begin
        rd_b = 1'b0;
        forever begin
            @(negedge clk);
            if (brk_b) brk_cnt_b++;
            if (rd_b) begin
                rd_b = 1'b0;
            end else if (auto_b && dv_b && q_b.size() != 0) begin
                wb = q_b.pop_front();
                chk("b_dout", dout_b, wb.d);
                chk("b_perr", perr_b, wb.pe);
                chk("b_ferr", ferr_b, wb.fe);
                rd_b = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] d;
        bit pe, pv, pb, s0;
        rst_a = 0; rst_b = 0; rx_a = 1; rx_b = 1;
        pen_a = 0; peven_a = 0; pen_b = 0; peven_b = 0;
        ovr_clr_a = 0; ovr_clr_b = 0;
        repeat (3) @(negedge clk);
        chk("a_reset_outputs", {dout_a, dv_a, perr_a, ferr_a, brk_a, ovr_a, busy_a}, 0);
        chk("b_reset_outputs", {dout_b, dv_b, perr_b, ferr_b, brk_b, ovr_b, busy_b}, 0);
        rst_a = 1; rst_b = 1;
        repeat (2) @(negedge clk);
        auto_a = 1; auto_b = 1;

        // 8N1 basic word
        send(0, 9'h0A5, 0, 0, 0, 1, 1, -1, 0);
        drain(0, "t1_a5");

        // parity cases on 0x37
        send(0, 9'h037, 1, 1, 1, 1, 1, -1, 0);
        send(0, 9'h037, 1, 1, 0, 1, 1, -1, 0);
        send(0, 9'h037, 1, 0, 0, 1, 1, -1, 0);
        drain(0, "t2_parity");

        // start glitch: 4 clocks low
        drive(0, 1'b0, 4, -1);
        chk("t3_glitch_busy_high", busy_a, 1);
        drive(0, 1'b1, 2 * BIT, -1);
        chk("t3_glitch_busy_low", busy_a, 0);
        chk("t3_glitch_no_push", dv_a, 0);
        send(0, 9'h05A, 0, 0, 0, 1, 1, 3, 8);
        drain(0, "t3_after_glitch");

        // break: 12 bit times low
        pen_a = 0;
        drive(0, 1'b0, 11 * BIT, -1);
        chk("t4_brk_waithigh_busy", busy_a, 0);
        chk("t4_brk_pushed", dv_a, 1);
        drive(0, 1'b0, BIT, -1);
        q_a.push_back(word_t'{d: 9'd0, pe: 1'b0, fe: 1'b1});
        brk_exp_a++;
        drive(0, 1'b1, 2 * BIT, -1);
        drain(0, "t4_break");
        chk("t4_brk_count", brk_cnt_a, brk_exp_a);
        send(0, 9'h011, 0, 0, 0, 1, 1, -1, 0);
        drain(0, "t4_after_break");

        // randomized frames with spikes, parity and framing errors
        for (int k = 0; k < 24; k++) begin
            d  = 9'($urandom_range(0, 255));
            pe = 1'($urandom_range(0, 1));
            pv = 1'($urandom_range(0, 1));
            pb = 1'($urandom_range(0, 1));
            s0 = ($urandom_range(0, 3) != 0);
            if (k % 8 == 5) begin d = 9'd0; s0 = 0; end
            send(0, d, pe, pv, pb, s0, 1, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
        end
        drain(0, "rand");

        // overflow: five words, no reads
        auto_a = 0;
        for (int v = 1; v <= 5; v++) send(0, 9'(v), 0, 0, 0, 1, 1, -1, 0);
        chk("t5_overrun_set", ovr_a, ovr_exp_a);
        chk("t5_full_valid", dv_a, 1);
        auto_a = 1;
        drain(0, "t5_fill");
        chk("t5_overrun_sticky", ovr_a, ovr_exp_a);
        @(negedge clk); ovr_clr_a = 1;
        @(negedge clk); ovr_clr_a = 0;
        ovr_exp_a = 0;
        chk("t5_overrun_cleared", ovr_a, ovr_exp_a);

        // pop concurrent with push while full
        auto_a = 0;
        for (int v = 0; v < 4; v++) send(0, 9'($urandom_range(0, 255)), 0, 0, 0, 1, 1, -1, 0);
        conc_arm_a = 1;
        send(0, 9'h0C3, 0, 0, 0, 1, 1, -1, 0);
        chk("t5_conc_pop_done", conc_arm_a, 0);
        chk("t5_conc_no_overrun", ovr_a, ovr_exp_a);
        auto_a = 1;
        drain(0, "t5_conc");

        // 7-bit, two stops, odd parity
        send(1, 9'h02B, 1, 0, ~(^7'h2B), 1, 0, -1, 0);
        send(1, 9'h055, 1, 0, ~(^7'h55), 1, 1, -1, 0);
        send(1, 9'h03C, 1, 0, ^7'h3C, 1, 1, -1, 0);
        drain(1, "t6_b");

        // reset mid-DATA on instance B with a word waiting
        auto_b = 0;
        send(1, 9'h012, 0, 0, 0, 1, 1, -1, 0);
        chk("t6_pre_rst_valid", dv_b, 1);
        drive(1, 1'b0, BIT, -1);
        drive(1, 1'b1, BIT, -1);
        drive(1, 1'b0, BIT / 2, -1);
        chk("t6_pre_rst_busy", busy_b, 1);
        @(negedge clk);
        rst_b = 0; rx_b = 1;
        #1;
        chk("t6_rst_valid", dv_b, 0);
        chk("t6_rst_busy", busy_b, 0);
        q_b.delete();
        repeat (2) @(negedge clk);
        rst_b = 1;
        repeat (2) @(negedge clk);
        chk("t6_post_rst_valid", dv_b, 0);
        auto_b = 1;
        send(1, 9'h06C, 1, 1, ^7'h6C, 1, 1, -1, 0);
        drain(1, "t6_after_rst");

        chk("a_brk_total", brk_cnt_a, brk_exp_a);
        chk("b_brk_total", brk_cnt_b, brk_exp_b);
        chk("b_no_overrun", ovr_b, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
